mem_port_arbiter: RTL and testbench

- Shares the single-ported unified memory between two requesters.
- Port 0 is the rv32i multicycle core's fetch/load/store port. Port 1 is a secondary master, such as the program loader or a debug/DMA engine.
- Grants one command per cycle using round-robin. Tracks a single outstanding read and routes the returned data to its owner.
- Sits between the core's mem_* interface and the memory model. The core is stalled through its ena input whenever m0_req is high and m0_gnt is low.

---
 rtl/mem_port_arbiter_if.sv | 46 ++++
 rtl/mem_port_arbiter.sv | 102 ++++++++++
 tb/tb_mem_port_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Command/response bundle between two memory masters, the arbiter and the
// single-ported memory. The arbiter takes the slave view, the environment the master view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              m0_req;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wr_data;
  logic              m0_wr_ena;
  logic              m0_gnt;
  logic [DATA_W-1:0] m0_rd_data;
  logic              m0_rd_valid;

  logic              m1_req;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wr_data;
  logic              m1_wr_ena;
  logic              m1_gnt;
  logic [DATA_W-1:0] m1_rd_data;
  logic              m1_rd_valid;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic              mem_wr_ena;
  logic [DATA_W-1:0] mem_rd_data;
  logic              busy;

  modport slave (
    input  m0_req, m0_addr, m0_wr_data, m0_wr_ena,
    input  m1_req, m1_addr, m1_wr_data, m1_wr_ena,
    input  mem_rd_data,
    output m0_gnt, m0_rd_data, m0_rd_valid,
    output m1_gnt, m1_rd_data, m1_rd_valid,
    output mem_addr, mem_wr_data, mem_wr_ena, busy
  );

  modport master (
    output m0_req, m0_addr, m0_wr_data, m0_wr_ena,
    output m1_req, m1_addr, m1_wr_data, m1_wr_ena,
    output mem_rd_data,
    input  m0_gnt, m0_rd_data, m0_rd_valid,
    input  m1_gnt, m1_rd_data, m1_rd_valid,
    input  mem_addr, mem_wr_data, mem_wr_ena, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between two masters,
// with one outstanding read whose data is steered back to its owner.
module mem_port_arbiter #(
  parameter int READ_LATENCY = 1,
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus
);

  typedef enum logic {IDLE, RD_WAIT} state_t;

  localparam logic [3:0] LAT = 4'(READ_LATENCY);

  state_t     state, state_nxt;
  logic       last_grant, last_grant_nxt;
  logic       owner, owner_nxt;
  logic [3:0] cnt, cnt_nxt;

  logic rd_return;
  logic eligible;
  logic both_req;
  logic grant_vld;
  logic sel;
  logic sel_we;

  // A grant slot opens when idle, or in the very cycle the pending read returns.
  assign rd_return = (state == RD_WAIT) && (cnt == 4'd1);
  assign eligible  = rst && ((state == IDLE) || rd_return);
  assign both_req  = bus.m0_req && bus.m1_req;
  assign grant_vld = eligible && (bus.m0_req || bus.m1_req);
  assign sel       = both_req ? ~last_grant : bus.m1_req;
  assign sel_we    = sel ? bus.m1_wr_ena : bus.m0_wr_ena;

  // NOTE: state registers use non-blocking assignments and reset asynchronously,
  // so every flop sees pre-edge values and an in-flight read is dropped at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      cnt        <= '0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      owner      <= owner_nxt;
      cnt        <= cnt_nxt;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_nxt       = state;
    last_grant_nxt  = last_grant;
    owner_nxt       = owner;
    cnt_nxt         = cnt;
    bus.m0_gnt      = 1'b0;
    bus.m1_gnt      = 1'b0;
    bus.m0_rd_valid = 1'b0;
    bus.m1_rd_valid = 1'b0;
    bus.m0_rd_data  = '0;
    bus.m1_rd_data  = '0;
    bus.mem_addr    = '0;
    bus.mem_wr_data = '0;
    bus.mem_wr_ena  = 1'b0;
    bus.busy        = (state == RD_WAIT);

    if (state == RD_WAIT) begin
      cnt_nxt = cnt - 4'd1;
      if (rd_return) state_nxt = IDLE;
    end

    if (rd_return) begin
      if (owner) begin
        bus.m1_rd_valid = 1'b1;
        bus.m1_rd_data  = bus.mem_rd_data;
      end else begin
        bus.m0_rd_valid = 1'b1;
        bus.m0_rd_data  = bus.mem_rd_data;
      end
    end

    if (grant_vld) begin
      bus.m0_gnt      = ~sel;
      bus.m1_gnt      = sel;
      bus.mem_addr    = sel ? bus.m1_addr    : bus.m0_addr;
      bus.mem_wr_data = sel ? bus.m1_wr_data : bus.m0_wr_data;
      bus.mem_wr_ena  = sel_we;
      last_grant_nxt  = sel;
      // A read granted on the return cycle reloads the counter and stays in RD_WAIT.
      if (!sel_we) begin
        state_nxt = RD_WAIT;
        cnt_nxt   = LAT;
        owner_nxt = sel;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: four arbiter instances at READ_LATENCY 1..4, each backed by
// a delay-line memory model returning a known function of the read address.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus2 ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus3 ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus4 ();

  mem_port_arbiter #(.READ_LATENCY(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
  mem_port_arbiter #(.READ_LATENCY(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));
  mem_port_arbiter #(.READ_LATENCY(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));
  mem_port_arbiter #(.READ_LATENCY(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

  // Memory contents: 0x10 holds 0xDEADBEEF, every other word holds 0xA5A50000 | addr.
  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return (a == 32'h10) ? 32'hDEADBEEF : (32'hA5A5_0000 | a);
  endfunction

  logic [31:0] p1 [8];
  logic [31:0] p2 [8];
  logic [31:0] p3 [8];
  logic [31:0] p4 [8];

  always @(posedge clk) begin
    p1[0] <= mem_val(bus1.mem_addr);
    p2[0] <= mem_val(bus2.mem_addr);
    p3[0] <= mem_val(bus3.mem_addr);
    p4[0] <= mem_val(bus4.mem_addr);
    for (int i = 1; i < 8; i++) begin
      p1[i] <= p1[i-1];
      p2[i] <= p2[i-1];
      p3[i] <= p3[i-1];
      p4[i] <= p4[i-1];
    end
  end

  assign bus1.mem_rd_data = p1[0];
  assign bus2.mem_rd_data = p2[1];
  assign bus3.mem_rd_data = p3[2];
  assign bus4.mem_rd_data = p4[3];

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic init_inputs();
    {bus1.m0_req, bus1.m0_addr, bus1.m0_wr_data, bus1.m0_wr_ena} = '0;
    {bus1.m1_req, bus1.m1_addr, bus1.m1_wr_data, bus1.m1_wr_ena} = '0;
    {bus2.m0_req, bus2.m0_addr, bus2.m0_wr_data, bus2.m0_wr_ena} = '0;
    {bus2.m1_req, bus2.m1_addr, bus2.m1_wr_data, bus2.m1_wr_ena} = '0;
    {bus3.m0_req, bus3.m0_addr, bus3.m0_wr_data, bus3.m0_wr_ena} = '0;
    {bus3.m1_req, bus3.m1_addr, bus3.m1_wr_data, bus3.m1_wr_ena} = '0;
    {bus4.m0_req, bus4.m0_addr, bus4.m0_wr_data, bus4.m0_wr_ena} = '0;
    {bus4.m1_req, bus4.m1_addr, bus4.m1_wr_data, bus4.m1_wr_ena} = '0;
  endtask

  task automatic test_reset();
    logic [5:0]  flags [4];
    logic [31:0] addrs [4];
    rst = 1'b0;
    repeat (3) next_cycle();
    rst = 1'b1;
    sample();
    flags[0] = {bus1.m0_gnt, bus1.m1_gnt, bus1.m0_rd_valid, bus1.m1_rd_valid, bus1.mem_wr_ena, bus1.busy};
    flags[1] = {bus2.m0_gnt, bus2.m1_gnt, bus2.m0_rd_valid, bus2.m1_rd_valid, bus2.mem_wr_ena, bus2.busy};
    flags[2] = {bus3.m0_gnt, bus3.m1_gnt, bus3.m0_rd_valid, bus3.m1_rd_valid, bus3.mem_wr_ena, bus3.busy};
    flags[3] = {bus4.m0_gnt, bus4.m1_gnt, bus4.m0_rd_valid, bus4.m1_rd_valid, bus4.mem_wr_ena, bus4.busy};
    addrs[0] = bus1.mem_addr;
    addrs[1] = bus2.mem_addr;
    addrs[2] = bus3.mem_addr;
    addrs[3] = bus4.mem_addr;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (flags[i] !== 6'b0) begin
        errors++;
        $display("FAIL reset_flags inst%0d got %b want 000000", i, flags[i]);
      end
      checks++;
      if (addrs[i] !== 32'h0) begin
        errors++;
        $display("FAIL reset_addr inst%0d got %h want 0", i, addrs[i]);
      end
    end
  endtask

  task automatic test_single_read();
    next_cycle();
    bus1.m0_req = 1'b1; bus1.m0_addr = 32'h10; bus1.m0_wr_ena = 1'b0;
    sample();
    checks++;
    if ({bus1.m0_gnt, bus1.m1_gnt, bus1.m0_rd_valid, bus1.busy} !== 4'b1000) begin
      errors++;
      $display("FAIL single_read_gnt got gnt0=%b gnt1=%b rv0=%b busy=%b want 1 0 0 0",
               bus1.m0_gnt, bus1.m1_gnt, bus1.m0_rd_valid, bus1.busy);
    end
    checks++;
    if (bus1.mem_addr !== 32'h10 || bus1.mem_wr_ena !== 1'b0) begin
      errors++;
      $display("FAIL single_read_cmd got addr=%h we=%b want 00000010 0", bus1.mem_addr, bus1.mem_wr_ena);
    end
    next_cycle();
    bus1.m0_req = 1'b0;
    sample();
    checks++;
    if ({bus1.m0_rd_valid, bus1.m1_rd_valid, bus1.busy} !== 3'b101) begin
      errors++;
      $display("FAIL single_read_valid got rv0=%b rv1=%b busy=%b want 1 0 1",
               bus1.m0_rd_valid, bus1.m1_rd_valid, bus1.busy);
    end
    checks++;
    if (bus1.m0_rd_data !== 32'hDEADBEEF || bus1.m1_rd_data !== 32'h0) begin
      errors++;
      $display("FAIL single_read_data got d0=%h d1=%h want deadbeef 00000000", bus1.m0_rd_data, bus1.m1_rd_data);
    end
    next_cycle();
    sample();
    checks++;
    if ({bus1.m0_rd_valid, bus1.m1_rd_valid, bus1.busy} !== 3'b000) begin
      errors++;
      $display("FAIL single_read_after got rv0=%b rv1=%b busy=%b want 0 0 0",
               bus1.m0_rd_valid, bus1.m1_rd_valid, bus1.busy);
    end
  endtask

  task automatic test_contention();
    next_cycle();
    bus2.m0_req = 1'b1; bus2.m0_addr = 32'h100; bus2.m0_wr_data = 32'd1; bus2.m0_wr_ena = 1'b1;
    bus2.m1_req = 1'b1; bus2.m1_addr = 32'h200; bus2.m1_wr_data = 32'd2; bus2.m1_wr_ena = 1'b1;
    for (int c = 0; c < 4; c++) begin
      logic [1:0]  exp_gnt;
      logic [31:0] exp_addr;
      logic [31:0] exp_data;
      exp_gnt  = (c % 2 == 0) ? 2'b01 : 2'b10;
      exp_addr = (c % 2 == 0) ? 32'h100 : 32'h200;
      exp_data = (c % 2 == 0) ? 32'd1 : 32'd2;
      sample();
      checks++;
      if ({bus2.m1_gnt, bus2.m0_gnt} !== exp_gnt || bus2.mem_wr_ena !== 1'b1) begin
        errors++;
        $display("FAIL contention_gnt c%0d got gnt1:gnt0=%b we=%b want %b 1",
                 c, {bus2.m1_gnt, bus2.m0_gnt}, bus2.mem_wr_ena, exp_gnt);
      end
      checks++;
      if (bus2.mem_addr !== exp_addr || bus2.mem_wr_data !== exp_data) begin
        errors++;
        $display("FAIL contention_bus c%0d got addr=%h data=%h want %h %h",
                 c, bus2.mem_addr, bus2.mem_wr_data, exp_addr, exp_data);
      end
      next_cycle();
    end
    bus2.m0_req = 1'b0;
    bus2.m1_req = 1'b0;
    sample();
    checks++;
    if (bus2.busy !== 1'b0 || bus2.mem_wr_ena !== 1'b0) begin
      errors++;
      $display("FAIL contention_idle got busy=%b we=%b want 0 0", bus2.busy, bus2.mem_wr_ena);
    end
  endtask

  task automatic test_read_blocking();
    // Prime with an m0 write so that m1 wins the following tie.
    next_cycle();
    bus3.m0_req = 1'b1; bus3.m0_addr = 32'h300; bus3.m0_wr_data = 32'd3; bus3.m0_wr_ena = 1'b1;
    sample();
    checks++;
    if (bus3.m0_gnt !== 1'b1) begin
      errors++;
      $display("FAIL blocking_prime got gnt0=%b want 1", bus3.m0_gnt);
    end
    next_cycle();
    bus3.m1_req = 1'b1; bus3.m1_addr = 32'h40; bus3.m1_wr_ena = 1'b0;
    sample();
    checks++;
    if ({bus3.m0_gnt, bus3.m1_gnt} !== 2'b01) begin
      errors++;
      $display("FAIL blocking_t0 got gnt0=%b gnt1=%b want 0 1", bus3.m0_gnt, bus3.m1_gnt);
    end
    next_cycle();
    bus3.m1_req = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      sample();
      checks++;
      if (bus3.m0_gnt !== 1'b0 || bus3.busy !== 1'b1 || bus3.mem_wr_ena !== 1'b0) begin
        errors++;
        $display("FAIL blocking_t%0d got gnt0=%b busy=%b we=%b want 0 1 0",
                 c, bus3.m0_gnt, bus3.busy, bus3.mem_wr_ena);
      end
      next_cycle();
    end
    sample();
    checks++;
    if ({bus3.m1_rd_valid, bus3.m0_gnt, bus3.m0_rd_valid} !== 3'b110 || bus3.m1_rd_data !== 32'hA5A50040) begin
      errors++;
      $display("FAIL blocking_t3 got rv1=%b gnt0=%b rv0=%b d1=%h want 1 1 0 a5a50040",
               bus3.m1_rd_valid, bus3.m0_gnt, bus3.m0_rd_valid, bus3.m1_rd_data);
    end
    checks++;
    if (bus3.mem_wr_ena !== 1'b1 || bus3.mem_addr !== 32'h300) begin
      errors++;
      $display("FAIL blocking_t3_cmd got we=%b addr=%h want 1 00000300", bus3.mem_wr_ena, bus3.mem_addr);
    end
    next_cycle();
    bus3.m0_req = 1'b0;
    sample();
    checks++;
    if (bus3.busy !== 1'b0 || bus3.m1_rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL blocking_t4 got busy=%b rv1=%b want 0 0", bus3.busy, bus3.m1_rd_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic        req_v  [7] = '{1, 1, 1, 1, 1, 0, 0};
    logic [31:0] addr_v [7] = '{32'h0, 32'h4, 32'h4, 32'h8, 32'h8, 32'h0, 32'h0};
    logic        gnt_v  [7] = '{1, 0, 1, 0, 1, 0, 0};
    logic        rv_v   [7] = '{0, 0, 1, 0, 1, 0, 1};
    logic [31:0] dat_v  [7] = '{32'h0, 32'h0, 32'hA5A50000, 32'h0, 32'hA5A50004, 32'h0, 32'hA5A50008};
    next_cycle();
    bus2.m0_wr_ena = 1'b0;
    for (int c = 0; c < 7; c++) begin
      bus2.m0_req  = req_v[c];
      bus2.m0_addr = addr_v[c];
      sample();
      checks++;
      if (bus2.m0_gnt !== gnt_v[c] || bus2.m0_rd_valid !== rv_v[c]) begin
        errors++;
        $display("FAIL b2b_ctl c%0d got gnt0=%b rv0=%b want %b %b",
                 c, bus2.m0_gnt, bus2.m0_rd_valid, gnt_v[c], rv_v[c]);
      end
      if (rv_v[c]) begin
        checks++;
        if (bus2.m0_rd_data !== dat_v[c]) begin
          errors++;
          $display("FAIL b2b_data c%0d got %h want %h", c, bus2.m0_rd_data, dat_v[c]);
        end
      end
      if (gnt_v[c]) begin
        checks++;
        if (bus2.mem_addr !== addr_v[c]) begin
          errors++;
          $display("FAIL b2b_addr c%0d got %h want %h", c, bus2.mem_addr, addr_v[c]);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_mid_read();
    int seen_rv = 0;
    bus4.m0_req = 1'b1; bus4.m0_addr = 32'h20; bus4.m0_wr_ena = 1'b0;
    sample();
    checks++;
    if (bus4.m0_gnt !== 1'b1) begin
      errors++;
      $display("FAIL midrst_gnt got gnt0=%b want 1", bus4.m0_gnt);
    end
    next_cycle();
    bus4.m0_req = 1'b0;
    sample();
    checks++;
    if (bus4.busy !== 1'b1) begin
      errors++;
      $display("FAIL midrst_busy_before got %b want 1", bus4.busy);
    end
    next_cycle();
    rst = 1'b0;
    sample();
    checks++;
    if (bus4.busy !== 1'b0 || bus4.m0_rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_in_reset got busy=%b rv0=%b want 0 0", bus4.busy, bus4.m0_rd_valid);
    end
    next_cycle();
    rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      sample();
      if (bus4.m0_rd_valid !== 1'b0 || bus4.busy !== 1'b0) seen_rv++;
      next_cycle();
    end
    checks++;
    if (seen_rv != 0) begin
      errors++;
      $display("FAIL midrst_no_valid got %0d cycles with rv0/busy set want 0", seen_rv);
    end
    bus4.m0_req = 1'b1; bus4.m0_addr = 32'h500; bus4.m0_wr_ena = 1'b1; bus4.m0_wr_data = 32'd5;
    bus4.m1_req = 1'b1; bus4.m1_addr = 32'h600; bus4.m1_wr_ena = 1'b1; bus4.m1_wr_data = 32'd6;
    sample();
    checks++;
    if ({bus4.m0_gnt, bus4.m1_gnt} !== 2'b10 || bus4.mem_addr !== 32'h500) begin
      errors++;
      $display("FAIL midrst_tie got gnt0=%b gnt1=%b addr=%h want 1 0 00000500",
               bus4.m0_gnt, bus4.m1_gnt, bus4.mem_addr);
    end
    next_cycle();
    bus4.m0_req = 1'b0;
    bus4.m1_req = 1'b0;
  endtask

  initial begin
    init_inputs();
    test_reset();
    test_single_read();
    test_contention();
    test_read_blocking();
    test_back_to_back();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
